// File: rtl/pong_score_pkg.sv
// rtl/pong_score_pkg.sv - shared BCD types and constant helpers for the score counter
package pong_score_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Converts a decimal constant (up to 8 digits) into packed BCD, digit 0 in [3:0].
  function automatic logic [31:0] to_bcd(input int value);
    logic [31:0] packed_bcd;
    int          v;
    packed_bcd = '0;
    v          = value;
    for (int i = 0; i < 8; i++) begin
      packed_bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return packed_bcd;
  endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// rtl/bcd_digit_addsub.sv - single BCD digit adder/subtractor with carry/borrow chain
module bcd_digit_addsub
  import pong_score_pkg::*;
(
  input  logic       sub,
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t result,
  output logic       cout
);

  logic [4:0] sum;
  logic [4:0] sub_amt;

  // cin/cout carry the borrow when sub is high.
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    sub_amt = {1'b0, b} + {4'b0, cin};
    result  = '0;
    cout    = 1'b0;
    if (sub) begin
      if ({1'b0, a} < sub_amt) begin
        result = 4'(({1'b0, a} + 5'd10) - sub_amt);
        cout   = 1'b1;
      end else begin
        result = 4'({1'b0, a} - sub_amt);
      end
    end else if (sum > 5'd9) begin
      result = 4'(sum - 5'd10);
      cout   = 1'b1;
    end else begin
      result = sum[3:0];
    end
  end

endmodule

// File: rtl/bcd_score_counter.sv
// rtl/bcd_score_counter.sv - N-digit BCD up/down score counter with wrap/saturate and win flag
module bcd_score_counter
  import pong_score_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int WRAP      = 1,
  parameter int WIN_SCORE = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                d_clr,
  input  logic                d_load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                d_inc,
  input  logic                d_dec,
  input  logic [3:0]          step,
  output logic [4*DIGITS-1:0] digits,
  output logic                ovf,
  output logic                unf,
  output logic                is_zero,
  output logic                is_max,
  output logic                win
);

  localparam int              W         = 4 * DIGITS;
  localparam logic [31:0]     WIN_FULL  = to_bcd(WIN_SCORE);
  localparam logic [W-1:0]    WIN_BCD   = WIN_FULL[W-1:0];
  localparam logic [W-1:0]    ALL_NINES = {DIGITS{BCD_MAX}};

  logic [W-1:0]  digits_q, digits_d;
  logic [W-1:0]  load_clamped;
  logic [W-1:0]  arith;
  logic [DIGITS:0] carry;
  logic          ovf_q, ovf_d, unf_q, unf_d, win_q, win_d;
  bcd_digit_t    step_c;
  logic          arith_cmd;

  assign step_c    = (step > BCD_MAX) ? BCD_MAX : step;
  assign arith_cmd = (d_inc ^ d_dec) && (step_c != 4'd0);
  assign carry[0]  = 1'b0;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign load_clamped[4*gi +: 4] =
      (load_val[4*gi +: 4] > BCD_MAX) ? BCD_MAX : load_val[4*gi +: 4];

    bcd_digit_addsub u_digit (
      .sub    (d_dec),
      .a      (digits_q[4*gi +: 4]),
      .b      ((gi == 0) ? step_c : 4'd0),
      .cin    (carry[gi]),
      .result (arith[4*gi +: 4]),
      .cout   (carry[gi+1])
    );
  end

  // With valid BCD digits, a plain binary compare of the packed vector
  // orders values exactly like the decimal numbers they encode.
  always_comb begin
    digits_d = digits_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    win_d    = win_q;
    if (d_clr) begin
      digits_d = '0;
      win_d    = 1'b0;
    end else if (d_load) begin
      digits_d = load_clamped;
      win_d    = win_q | (load_clamped >= WIN_BCD);
    end else if (arith_cmd) begin
      digits_d = arith;
      if (carry[DIGITS]) begin
        if (d_inc) begin
          ovf_d = 1'b1;
          if (WRAP == 0) digits_d = ALL_NINES;
        end else begin
          unf_d = 1'b1;
          if (WRAP == 0) digits_d = '0;
        end
      end
      win_d = win_q | (digits_d >= WIN_BCD);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      win_q    <= win_d;
    end
  end

  assign digits  = digits_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign win     = win_q;
  assign is_zero = (digits_q == '0);
  assign is_max  = (digits_q == ALL_NINES);

endmodule

// File: tb/tb_bcd_score_counter.sv
// tb/tb_bcd_score_counter.sv - self-checking bench for bcd_score_counter
module tb_bcd_score_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        d_clr = 1'b0, d_load = 1'b0, d_inc = 1'b0, d_dec = 1'b0;
  logic [15:0] load_val = '0;
  logic [3:0]  step = '0;

  logic [7:0]  dig_w, dig_s;
  logic [15:0] dig_4;
  logic        ovf_w, unf_w, zero_w, max_w, win_w;
  logic        ovf_s, unf_s, zero_s, max_s, win_s;
  logic        ovf_4, unf_4, zero_4, max_4, win_4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_score_counter #(.DIGITS(2), .WRAP(1), .WIN_SCORE(11)) dut_w (
    .clk(clk), .reset(reset), .d_clr(d_clr), .d_load(d_load), .load_val(load_val[7:0]),
    .d_inc(d_inc), .d_dec(d_dec), .step(step), .digits(dig_w), .ovf(ovf_w), .unf(unf_w),
    .is_zero(zero_w), .is_max(max_w), .win(win_w));

  bcd_score_counter #(.DIGITS(2), .WRAP(0), .WIN_SCORE(11)) dut_s (
    .clk(clk), .reset(reset), .d_clr(d_clr), .d_load(d_load), .load_val(load_val[7:0]),
    .d_inc(d_inc), .d_dec(d_dec), .step(step), .digits(dig_s), .ovf(ovf_s), .unf(unf_s),
    .is_zero(zero_s), .is_max(max_s), .win(win_s));

  bcd_score_counter #(.DIGITS(4), .WRAP(1), .WIN_SCORE(11)) dut_4 (
    .clk(clk), .reset(reset), .d_clr(d_clr), .d_load(d_load), .load_val(load_val),
    .d_inc(d_inc), .d_dec(d_dec), .step(step), .digits(dig_4), .ovf(ovf_4), .unf(unf_4),
    .is_zero(zero_4), .is_max(max_4), .win(win_4));

  // Reference model: integer score per instance, decimal arithmetic.
  localparam int MD [3] = '{2, 2, 4};
  localparam int MW [3] = '{1, 0, 1};
  int mval [3];
  bit movf [3], munf [3], mwin [3];

  function automatic logic [15:0] enc(input int v, input int nd);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < nd; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int dec_load(input logic [15:0] lv, input int nd);
    int v, p, dg;
    v = 0;
    p = 1;
    for (int d = 0; d < nd; d++) begin
      dg = int'(lv[4*d +: 4]);
      if (dg > 9) dg = 9;
      v = v + dg * p;
      p = p * 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mval[k] = 0; movf[k] = 0; munf[k] = 0; mwin[k] = 0;
    end
  endtask

  task automatic model_step();
    int s, t, mx;
    s = (int'(step) > 9) ? 9 : int'(step);
    for (int k = 0; k < 3; k++) begin
      mx = (MD[k] == 2) ? 99 : 9999;
      movf[k] = 0;
      munf[k] = 0;
      if (d_clr) begin
        mval[k] = 0;
        mwin[k] = 0;
      end else if (d_load) begin
        mval[k] = dec_load(load_val, MD[k]);
        if (mval[k] >= 11) mwin[k] = 1;
      end else if ((d_inc != d_dec) && s != 0) begin
        t = d_inc ? mval[k] + s : mval[k] - s;
        if (t > mx) begin
          movf[k] = 1;
          mval[k] = MW[k] ? t - (mx + 1) : mx;
        end else if (t < 0) begin
          munf[k] = 1;
          mval[k] = MW[k] ? t + mx + 1 : 0;
        end else begin
          mval[k] = t;
        end
        if (mval[k] >= 11) mwin[k] = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [15:0] d;
    logic o, u, z, m, w;
    int mx;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin d = {8'h0, dig_w}; o = ovf_w; u = unf_w; z = zero_w; m = max_w; w = win_w; end
        1: begin d = {8'h0, dig_s}; o = ovf_s; u = unf_s; z = zero_s; m = max_s; w = win_s; end
        default: begin d = dig_4; o = ovf_4; u = unf_4; z = zero_4; m = max_4; w = win_4; end
      endcase
      mx = (MD[k] == 2) ? 99 : 9999;
      chk($sformatf("model%0d.digits", k), 32'(d), 32'(enc(mval[k], MD[k])));
      chk($sformatf("model%0d.ovf", k), 32'(o), 32'(movf[k]));
      chk($sformatf("model%0d.unf", k), 32'(u), 32'(munf[k]));
      chk($sformatf("model%0d.win", k), 32'(w), 32'(mwin[k]));
      chk($sformatf("model%0d.is_zero", k), 32'(z), 32'(mval[k] == 0));
      chk($sformatf("model%0d.is_max", k), 32'(m), 32'(mval[k] == mx));
    end
  endtask

  task automatic do_cycle(input logic c, input logic l, input logic [15:0] lv,
                          input logic i, input logic dd, input logic [3:0] st);
    d_clr = c; d_load = l; load_val = lv; d_inc = i; d_dec = dd; step = st;
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    logic        clr, load;
    logic [15:0] lv;
    logic        inc, dec;
    logic [3:0]  st;
    logic [7:0]  exp_d;
    logic        exp_ovf, exp_unf, exp_win;
  } vec_t;

  vec_t tbl [17];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 4'd0,  8'h10, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd1,  8'h11, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd1,  8'h10, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd1,  8'h09, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd1,  8'h08, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 4'd0,  8'h03, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd7,  8'h96, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 16'h0095, 1'b0, 1'b0, 4'd0,  8'h95, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd12, 8'h04, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 16'h0055, 1'b1, 1'b0, 4'd1,  8'h00, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 16'h004F, 1'b0, 1'b1, 4'd1,  8'h49, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4'd3,  8'h49, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  8'h49, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0, 4'd0,  8'h99, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd1,  8'h00, 1'b1, 1'b0, 1'b1};

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.digits", 32'(dig_w), 32'h0);
    chk("reset.ovf_unf", 32'({ovf_w, unf_w}), 32'h0);
    chk("reset.win", 32'(win_w), 32'h0);
    chk("reset.is_zero", 32'(zero_w), 32'h1);
    chk("reset.is_max", 32'(max_w), 32'h0);
    check_all();
    reset = 1'b0;

    // Count up to 99 one at a time, then wrap.
    do_cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 99; i++) do_cycle(0, 0, 0, 1, 0, 4'd1);
    chk("count99.digits", 32'(dig_w), 32'h99);
    chk("count99.is_max", 32'(max_w), 32'h1);
    chk("count99.win", 32'(win_w), 32'h1);
    do_cycle(0, 0, 0, 1, 0, 4'd1);
    chk("wrap100.digits", 32'(dig_w), 32'h00);
    chk("wrap100.ovf", 32'(ovf_w), 32'h1);
    do_cycle(0, 0, 0, 0, 0, 4'd0);
    chk("wrap100.ovf_drop", 32'(ovf_w), 32'h0);

    do_cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      do_cycle(tbl[i].clr, tbl[i].load, tbl[i].lv, tbl[i].inc, tbl[i].dec, tbl[i].st);
      chk($sformatf("vec%0d.digits", i), 32'(dig_w), 32'(tbl[i].exp_d));
      chk($sformatf("vec%0d.ovf", i), 32'(ovf_w), 32'(tbl[i].exp_ovf));
      chk($sformatf("vec%0d.unf", i), 32'(unf_w), 32'(tbl[i].exp_unf));
      chk($sformatf("vec%0d.win", i), 32'(win_w), 32'(tbl[i].exp_win));
    end

    // Saturating instance at both bounds, including repeated pulses when held.
    do_cycle(0, 1, 16'h0097, 0, 0, 0);
    do_cycle(0, 0, 0, 1, 0, 4'd5);
    chk("sat_hi.digits", 32'(dig_s), 32'h99);
    chk("sat_hi.ovf", 32'(ovf_s), 32'h1);
    do_cycle(0, 0, 0, 1, 0, 4'd5);
    chk("sat_hi_again.digits", 32'(dig_s), 32'h99);
    chk("sat_hi_again.ovf", 32'(ovf_s), 32'h1);
    do_cycle(0, 1, 16'h0005, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 1, 4'd9);
    chk("sat_lo.digits", 32'(dig_s), 32'h00);
    chk("sat_lo.unf", 32'(unf_s), 32'h1);
    do_cycle(0, 0, 0, 0, 1, 4'd9);
    chk("sat_lo_again.digits", 32'(dig_s), 32'h00);
    chk("sat_lo_again.unf", 32'(unf_s), 32'h1);
    do_cycle(0, 0, 0, 0, 0, 4'd0);
    chk("sat_lo.unf_drop", 32'(unf_s), 32'h0);

    // Asynchronous reset in the middle of an increment burst.
    for (int i = 0; i < 5; i++) do_cycle(0, 0, 0, 1, 0, 4'd3);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst.digits_w", 32'(dig_w), 32'h0);
    chk("async_rst.digits_4", 32'(dig_4), 32'h0);
    chk("async_rst.win", 32'(win_w), 32'h0);
    chk("async_rst.is_zero", 32'(zero_w), 32'h1);
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;
    do_cycle(0, 0, 0, 1, 0, 4'd1);
    chk("post_rst.digits", 32'(dig_w), 32'h01);

    // Four-digit instance all the way to 9999 and over.
    do_cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9999; i++) do_cycle(0, 0, 0, 1, 0, 4'd1);
    chk("d4_max.digits", 32'(dig_4), 32'h9999);
    chk("d4_max.is_max", 32'(max_4), 32'h1);
    do_cycle(0, 0, 0, 1, 0, 4'd1);
    chk("d4_wrap.digits", 32'(dig_4), 32'h0000);
    chk("d4_wrap.ovf", 32'(ovf_4), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      do_cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0), 16'($urandom),
               1'($urandom), 1'($urandom), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
